// File: rtl/lpif_link_ctrl_pkg.sv
// Shared definitions for the LPIF link bring-up controller: state encoding
// and bit positions of the packed debug_status word.
package lpif_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PHY_WAIT   = 3'd1,
        ST_PHY_STABLE = 3'd2,
        ST_TX_ON      = 3'd3,
        ST_ALIGN_WAIT = 3'd4,
        ST_LINK_UP    = 3'd5,
        ST_RETRAIN    = 3'd6,
        ST_FAILED     = 3'd7
    } link_state_e;

    localparam int DBG_STATE_LSB  = 29;
    localparam int DBG_FAILED_BIT = 28;
    localparam int DBG_RETRY_LSB  = 20;
    localparam int DBG_TX_BIT     = 19;
    localparam int DBG_RX_BIT     = 18;
    localparam int DBG_PHY_BIT    = 17;
    localparam int DBG_ALIGN_BIT  = 16;
    localparam int DBG_TIMER_LSB  = 0;

endpackage

// File: rtl/lpif_link_online_ctrl.sv
// Link bring-up sequencer for the x16 LPIF half-rate datapath: qualifies PHY
// readiness, raises tx_online, waits for RX alignment, then raises rx_online.
module lpif_link_online_ctrl
    import lpif_link_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W     = 20,
    parameter int RETRY_W       = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int RETRAIN_HOLD  = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic                 link_enable,
    input  logic                 phy_ready,
    input  logic                 rx_align_done,
    input  logic                 rx_align_err,
    input  logic [TIMEOUT_W-1:0] align_timeout_value,
    input  logic [RETRY_W-1:0]   max_retry,
    output logic                 tx_online,
    output logic                 rx_online,
    output logic                 link_up,
    output logic [2:0]           link_state,
    output logic [RETRY_W-1:0]   retry_count,
    output logic [31:0]          debug_status
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int HD_W = $clog2(RETRAIN_HOLD + 1);

    link_state_e          state, state_nxt;
    logic [SC_W-1:0]      stable_cnt, stable_nxt;
    logic [TIMEOUT_W-1:0] timer, timer_nxt;
    logic [HD_W-1:0]      hold_cnt, hold_nxt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic                 go_retrain;
    logic                 tx_nxt, rx_nxt;
    logic [31:0]          dbg_nxt;

    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_cnt;
        timer_nxt  = timer;
        hold_nxt   = hold_cnt;
        retry_nxt  = retry_count;
        go_retrain = 1'b0;

        if (!link_enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_PHY_WAIT;
                ST_PHY_WAIT: begin
                    if (phy_ready) begin
                        state_nxt  = ST_PHY_STABLE;
                        stable_nxt = '0;
                    end
                end
                ST_PHY_STABLE: begin
                    if (!phy_ready)
                        state_nxt = ST_PHY_WAIT;
                    else if (stable_cnt == SC_W'(STABLE_CYCLES - 1))
                        state_nxt = ST_TX_ON;
                    else
                        stable_nxt = stable_cnt + SC_W'(1);
                end
                ST_TX_ON: begin
                    if (!phy_ready) begin
                        go_retrain = 1'b1;
                    end else begin
                        state_nxt = ST_ALIGN_WAIT;
                        timer_nxt = '0;
                    end
                end
                ST_ALIGN_WAIT: begin
                    // alignment wins over a timeout expiring in the same cycle
                    if (!phy_ready)
                        go_retrain = 1'b1;
                    else if (rx_align_done)
                        state_nxt = ST_LINK_UP;
                    else if ((align_timeout_value != '0) &&
                             (timer == align_timeout_value - TIMEOUT_W'(1)))
                        go_retrain = 1'b1;
                    else if (timer != '1)
                        timer_nxt = timer + TIMEOUT_W'(1);
                end
                ST_LINK_UP: begin
                    if (!phy_ready || rx_align_err)
                        go_retrain = 1'b1;
                end
                ST_RETRAIN: begin
                    if (hold_cnt == HD_W'(RETRAIN_HOLD - 1)) begin
                        if ((max_retry != '0) && (retry_count >= max_retry))
                            state_nxt = ST_FAILED;
                        else
                            state_nxt = ST_PHY_WAIT;
                    end else begin
                        hold_nxt = hold_cnt + HD_W'(1);
                    end
                end
                ST_FAILED: state_nxt = ST_FAILED;
                default:   state_nxt = ST_IDLE;
            endcase
        end

        if (go_retrain) begin
            state_nxt = ST_RETRAIN;
            hold_nxt  = '0;
            if (retry_count != '1)
                retry_nxt = retry_count + RETRY_W'(1);
        end

        if (state == ST_IDLE)
            retry_nxt = '0;

        tx_nxt = (state_nxt == ST_TX_ON) || (state_nxt == ST_ALIGN_WAIT) ||
                 (state_nxt == ST_LINK_UP);
        rx_nxt = (state_nxt == ST_LINK_UP);

        dbg_nxt = '0;
        dbg_nxt[DBG_STATE_LSB +: 3]  = state_nxt;
        dbg_nxt[DBG_FAILED_BIT]      = (state_nxt == ST_FAILED);
        dbg_nxt[DBG_RETRY_LSB +: 8]  = 8'(retry_nxt);
        dbg_nxt[DBG_TX_BIT]          = tx_nxt;
        dbg_nxt[DBG_RX_BIT]          = rx_nxt;
        dbg_nxt[DBG_PHY_BIT]         = phy_ready;
        dbg_nxt[DBG_ALIGN_BIT]       = rx_align_done;
        dbg_nxt[DBG_TIMER_LSB +: 16] = 16'(timer_nxt);
    end

    // Outputs are registered alongside the state so they are glitch-free Moore values
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state        <= ST_IDLE;
            stable_cnt   <= '0;
            timer        <= '0;
            hold_cnt     <= '0;
            retry_count  <= '0;
            tx_online    <= 1'b0;
            rx_online    <= 1'b0;
            link_up      <= 1'b0;
            debug_status <= '0;
        end else begin
            state        <= state_nxt;
            stable_cnt   <= stable_nxt;
            timer        <= timer_nxt;
            hold_cnt     <= hold_nxt;
            retry_count  <= retry_nxt;
            tx_online    <= tx_nxt;
            rx_online    <= rx_nxt;
            link_up      <= rx_nxt;
            debug_status <= dbg_nxt;
        end
    end

    assign link_state = state;

endmodule

// File: tb/tb_lpif_link_online_ctrl.sv
// Bench for lpif_link_online_ctrl: directed vector table, corner sequences and
// randomized traffic against a dwell-time reference model.
module tb_lpif_link_online_ctrl;

    localparam int TW   = 16;
    localparam int RW   = 4;
    localparam int SC   = 8;
    localparam int RH   = 16;
    localparam int TMAX = (1 << TW) - 1;
    localparam int RMAX = (1 << RW) - 1;

    logic          clk_wr = 1'b0;
    logic          rst_wr = 1'b1;
    logic          link_enable = 1'b0;
    logic          phy_ready = 1'b0;
    logic          rx_align_done = 1'b0;
    logic          rx_align_err = 1'b0;
    logic [TW-1:0] align_timeout_value = TW'(100);
    logic [RW-1:0] max_retry = '0;
    logic          tx_online, rx_online, link_up;
    logic [2:0]    link_state;
    logic [RW-1:0] retry_count;
    logic [31:0]   debug_status;

    lpif_link_online_ctrl #(
        .TIMEOUT_W(TW), .RETRY_W(RW), .STABLE_CYCLES(SC), .RETRAIN_HOLD(RH)
    ) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .link_enable(link_enable),
        .phy_ready(phy_ready), .rx_align_done(rx_align_done),
        .rx_align_err(rx_align_err), .align_timeout_value(align_timeout_value),
        .max_retry(max_retry), .tx_online(tx_online), .rx_online(rx_online),
        .link_up(link_up), .link_state(link_state), .retry_count(retry_count),
        .debug_status(debug_status)
    );

    initial forever #5 clk_wr = ~clk_wr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: tracks state, cycles spent in the current state,
    // retrains since IDLE and the last alignment-wait elapsed time.
    int          m_state = 0, m_dwell = 0, m_retry = 0, m_timer = 0;
    bit          m_tx = 0, m_rx = 0;
    logic [31:0] m_dbg = '0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        int nxt;
        bit rt;
        if (rst_wr) begin
            m_state = 0; m_dwell = 0; m_retry = 0; m_timer = 0;
            m_tx = 0; m_rx = 0; m_dbg = '0;
            return;
        end
        nxt = m_state;
        rt  = 0;
        if (!link_enable) nxt = 0;
        else begin
            case (m_state)
                0: nxt = 1;
                1: if (phy_ready) nxt = 2;
                2: if (!phy_ready) nxt = 1; else if (m_dwell == SC - 1) nxt = 3;
                3: if (!phy_ready) rt = 1; else nxt = 4;
                4: if (!phy_ready) rt = 1;
                   else if (rx_align_done) nxt = 5;
                   else if (align_timeout_value != 0 &&
                            m_dwell == int'(align_timeout_value) - 1) rt = 1;
                5: if (!phy_ready || rx_align_err) rt = 1;
                6: if (m_dwell == RH - 1)
                       nxt = (max_retry != 0 && m_retry >= int'(max_retry)) ? 7 : 1;
                default: ;
            endcase
        end
        if (rt) nxt = 6;
        if (m_state == 0) m_retry = 0;
        else if (rt) m_retry = imin(m_retry + 1, RMAX);
        m_dwell = (nxt != m_state) ? 0 : imin(m_dwell + 1, 1 << 24);
        if (nxt == 4) m_timer = imin(m_dwell, TMAX);
        m_state = nxt;
        m_tx = (nxt == 3) || (nxt == 4) || (nxt == 5);
        m_rx = (nxt == 5);
        m_dbg = {3'(nxt), (nxt == 7), 8'(m_retry), m_tx, m_rx, phy_ready,
                 rx_align_done, 16'(m_timer)};
    endtask

    task automatic step();
        logic [41:0] act, req;
        model_step();
        @(posedge clk_wr);
        #1;
        cyc++;
        act = {link_state, tx_online, rx_online, link_up, retry_count, debug_status};
        req = {3'(m_state), m_tx, m_rx, m_rx, RW'(m_retry), m_dbg};
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL model_cmp cycle %0d: got state=%0d tx=%0b rx=%0b up=%0b retry=%0d dbg=%08h, need state=%0d tx=%0b rx=%0b up=%0b retry=%0d dbg=%08h",
                     cyc, link_state, tx_online, rx_online, link_up, retry_count,
                     debug_status, m_state, m_tx, m_rx, m_rx, m_retry, m_dbg);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int lim, input string name);
        int k;
        k = 0;
        while (link_state !== tgt && k < lim) begin
            step();
            k++;
        end
        chk(name, 32'(link_state), 32'(tgt));
    endtask

    task automatic do_reset();
        rst_wr = 1'b1;
        step();
        rst_wr = 1'b0;
    endtask

    typedef struct {
        logic       rst, en, phy, done, err;
        logic [2:0] st;
        logic       tx, rx, up;
        logic [3:0] retry;
    } vec_t;

    function automatic vec_t mk(logic rst, logic en, logic phy, logic done, logic err,
                                logic [2:0] st, logic tx, logic rx, logic [3:0] retry);
        vec_t v;
        v.rst = rst; v.en = en; v.phy = phy; v.done = done; v.err = err;
        v.st = st; v.tx = tx; v.rx = rx; v.up = rx; v.retry = retry;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        int tx_rise, up_rise, n6;

        // PHY glitch in PHY_STABLE, bring-up, align error and disable
        tbl[0]  = mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 3'd2, 0, 0, 0);
        for (int i = 4; i <= 8; i++) tbl[i] = mk(0, 1, 1, 0, 0, 3'd2, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 0);
        for (int i = 10; i <= 17; i++) tbl[i] = mk(0, 1, 1, 0, 0, 3'd2, 0, 0, 0);
        tbl[18] = mk(0, 1, 1, 0, 0, 3'd3, 1, 0, 0);
        tbl[19] = mk(0, 1, 1, 0, 0, 3'd4, 1, 0, 0);
        tbl[20] = mk(0, 1, 1, 1, 0, 3'd5, 1, 1, 0);
        tbl[21] = mk(0, 1, 1, 0, 0, 3'd5, 1, 1, 0);
        tbl[22] = mk(0, 1, 1, 0, 1, 3'd6, 0, 0, 1);
        tbl[23] = mk(0, 1, 1, 0, 1, 3'd6, 0, 0, 1);
        tbl[24] = mk(0, 0, 1, 0, 0, 3'd0, 0, 0, 1);
        tbl[25] = mk(0, 0, 1, 0, 0, 3'd0, 0, 0, 0);

        align_timeout_value = TW'(100);
        max_retry = '0;
        for (int i = 0; i < 26; i++) begin
            rst_wr = tbl[i].rst; link_enable = tbl[i].en; phy_ready = tbl[i].phy;
            rx_align_done = tbl[i].done; rx_align_err = tbl[i].err;
            step();
            chk($sformatf("tbl[%0d]", i),
                32'({link_state, tx_online, rx_online, link_up, retry_count}),
                32'({tbl[i].st, tbl[i].tx, tbl[i].rx, tbl[i].up, tbl[i].retry}));
        end
        rx_align_err = 1'b0;
        chk("reset_dbg_after_tbl0_skip", 32'(debug_status[28]), 32'd0);

        // Nominal bring-up timing
        link_enable = 1'b0; do_reset();
        chk("reset_state", {29'd0, link_state}, 32'd0);
        chk("reset_dbg", debug_status, 32'd0);
        link_enable = 1'b1; phy_ready = 1'b1; rx_align_done = 1'b0;
        tx_rise = -1; up_rise = -1;
        for (int c = 0; c < 25; c++) begin
            rx_align_done = (c >= 20);
            step();
            if (tx_online && tx_rise < 0) tx_rise = c + 1;
            if (link_up && up_rise < 0) up_rise = c + 1;
        end
        chk("nom_tx_rise", 32'(tx_rise), 32'd10);
        chk("nom_up_rise", 32'(up_rise), 32'd21);
        chk("nom_rx_online", 32'(rx_online), 32'd1);
        chk("nom_retry", 32'(retry_count), 32'd0);

        // Alignment timeout until FAILED, then software restart
        link_enable = 1'b0; rx_align_done = 1'b0; do_reset();
        align_timeout_value = TW'(10); max_retry = RW'(2);
        link_enable = 1'b1; phy_ready = 1'b1;
        wait_state(3'd7, 300, "to_failed");
        chk("failed_retry", 32'(retry_count), 32'd2);
        chk("failed_outs", 32'({tx_online, rx_online, link_up}), 32'd0);
        chk("failed_dbg_bit", 32'(debug_status[28]), 32'd1);
        for (int k = 0; k < 5; k++) step();
        chk("failed_sticky", 32'(link_state), 32'd7);
        link_enable = 1'b0; step();
        chk("disable_idle", 32'(link_state), 32'd0);
        link_enable = 1'b1; step();
        chk("restart_retry_clr", 32'(retry_count), 32'd0);
        chk("restart_phy_wait", 32'(link_state), 32'd1);
        wait_state(3'd3, 40, "restart_tx_on");

        // rx_align_err in LINK_UP: hold low, then relock by itself
        link_enable = 1'b0; do_reset();
        align_timeout_value = TW'(100); max_retry = '0;
        link_enable = 1'b1; rx_align_done = 1'b1;
        wait_state(3'd5, 60, "err_linkup");
        rx_align_err = 1'b1; step(); rx_align_err = 1'b0;
        chk("err_outs_low", 32'({tx_online, rx_online, link_up}), 32'd0);
        chk("err_retry", 32'(retry_count), 32'd1);
        n6 = (link_state == 3'd6) ? 1 : 0;
        for (int k = 0; k < 100 && !link_up; k++) begin
            step();
            if (link_state == 3'd6) n6++;
        end
        chk("retrain_hold_len", 32'(n6), 32'(RH));
        chk("relock_up", 32'(link_up), 32'd1);
        chk("relock_retry", 32'(retry_count), 32'd1);

        // Alignment arriving on the timeout-expiry cycle
        link_enable = 1'b0; rx_align_done = 1'b0; do_reset();
        align_timeout_value = TW'(10);
        link_enable = 1'b1;
        wait_state(3'd4, 60, "simul_align_wait");
        for (int k = 0; k < 20 && debug_status[15:0] != 16'd9; k++) step();
        chk("simul_timer9", 32'(debug_status[15:0]), 32'd9);
        rx_align_done = 1'b1; step();
        chk("simul_linkup", 32'(link_state), 32'd5);
        chk("simul_retry", 32'(retry_count), 32'd0);

        // Timeout disabled: timer saturates without wrapping
        link_enable = 1'b0; rx_align_done = 1'b0; do_reset();
        align_timeout_value = '0;
        link_enable = 1'b1;
        wait_state(3'd4, 60, "sat_align_wait");
        for (int k = 0; k < TMAX + 20; k++) step();
        chk("sat_state", 32'(link_state), 32'd4);
        chk("sat_timer", 32'(debug_status[15:0]), 32'hFFFF);

        // Reset pulse while LINK_UP
        rx_align_done = 1'b1;
        wait_state(3'd5, 10, "rst_linkup");
        rst_wr = 1'b1; step(); rst_wr = 1'b0;
        chk("rst_outs", 32'({link_state, tx_online, rx_online, link_up, retry_count}), 32'd0);
        chk("rst_dbg", debug_status, 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if (k % 250 == 0) begin
                align_timeout_value = TW'($urandom_range(0, 30));
                max_retry = RW'($urandom_range(0, 3));
            end
            rst_wr        = ($urandom_range(0, 999) < 2);
            link_enable   = ($urandom_range(0, 199) != 0);
            phy_ready     = ($urandom_range(0, 99) < 96);
            if ($urandom_range(0, 99) < 15) rx_align_done = ~rx_align_done;
            rx_align_err  = ($urandom_range(0, 99) < 3);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lpif_link_online_ctrl.md
Name: lpif_link_online_ctrl

Overview:
- Sequences link bring-up for the x16 LPIF half-rate datapath.
- Qualifies PHY readiness, raises tx_online, waits for RX marker alignment, then raises rx_online.
- Supervises the running link and retrains on alignment loss or PHY drop.
- Its tx_online/rx_online outputs feed the auto-sync (delay/marker) logic in front of the TX/RX concat.

Parameters:
- TIMEOUT_W, 20, width of alignment timeout counter and align_timeout_value.
- RETRY_W, 4, width of retry counter and max_retry; legal range 1..8.
- STABLE_CYCLES, 8, consecutive phy_ready cycles required before tx_online; legal range >=1.
- RETRAIN_HOLD, 16, cycles tx_online/rx_online are held low in RETRAIN; legal range >=1.

Ports:
- clk_wr  in  1  single clock; all logic on rising edge.
- rst_wr  in  1  synchronous, active-high reset.
- link_enable  in  1  software enable; level.
- phy_ready  in  1  AND of all 16 channel PHY-ready indications.
- rx_align_done  in  1  RX word/marker alignment achieved; level.
- rx_align_err  in  1  single-cycle pulse on alignment loss.
- align_timeout_value  in  TIMEOUT_W  cycles allowed in ALIGN_WAIT; 0 disables timeout.
- max_retry  in  RETRY_W  retrain attempts before FAILED; 0 means unlimited.
- tx_online  out  1  to auto-sync tx_online.
- rx_online  out  1  to auto-sync rx_online.
- link_up  out  1  link operational.
- link_state  out  3  current FSM state encoding.
- retry_count  out  RETRY_W  retrains since IDLE, saturating.
- debug_status  out  32  packed status.

Behaviour:
- Reset: state IDLE; all outputs 0; stable counter, timer, hold counter and retry_count = 0.
- States and encoding: IDLE=0, PHY_WAIT=1, PHY_STABLE=2, TX_ON=3, ALIGN_WAIT=4, LINK_UP=5, RETRAIN=6, FAILED=7.
- Outputs are Moore and registered with the state.
- tx_online=1 in TX_ON, ALIGN_WAIT and LINK_UP.
- rx_online=1 and link_up=1 in LINK_UP only.
- Transition priority, highest first: link_enable=0 -> IDLE from any state; then per-state rules below.
- IDLE: link_enable=1 -> PHY_WAIT. retry_count is cleared while in IDLE.
- PHY_WAIT: phy_ready=1 -> PHY_STABLE with stable counter cleared.
- PHY_STABLE: counter increments each cycle phy_ready=1; phy_ready=0 -> PHY_WAIT. When counter reaches STABLE_CYCLES-1 with phy_ready=1 -> TX_ON. Net result: STABLE_CYCLES cycles in PHY_STABLE.
- TX_ON: phy_ready=0 -> RETRAIN; else -> ALIGN_WAIT after 1 cycle, timer cleared.
- ALIGN_WAIT: checked in order:
  - phy_ready=0 -> RETRAIN.
  - rx_align_done=1 -> LINK_UP; this wins over a simultaneous timeout.
  - align_timeout_value!=0 and timer==align_timeout_value-1 -> RETRAIN.
  - otherwise timer increments; it saturates at all-ones and never wraps.
- LINK_UP: phy_ready=0 or rx_align_err=1 -> RETRAIN. rx_align_done falling alone does not retrain; rx_align_err is the only loss indication.
- RETRAIN entry: retry_count increments, saturating at all-ones; hold counter cleared.
- RETRAIN: after RETRAIN_HOLD cycles, exit test uses the updated retry_count:
  - max_retry!=0 and retry_count>=max_retry -> FAILED.
  - otherwise -> PHY_WAIT.
- FAILED: sticky; outputs 0; exits only via link_enable=0 -> IDLE.
- Reset asserted mid-operation: next edge forces the reset state regardless of FSM state.
- rx_align_err outside LINK_UP is ignored.
- debug_status fields:
  - [31:29] link_state
  - [28] (state==FAILED)
  - [27:20] retry_count zero-extended
  - [19] tx_online
  - [18] rx_online
  - [17] phy_ready
  - [16] rx_align_done
  - [15:0] timer[15:0]
- debug_status is registered.

Decomposition:
- Package lpif_link_ctrl_pkg holds:
  - link_state_e enum, 3-bit, encodings as listed above.
  - debug_status field position constants.
- No sub-module; the stable, timeout and hold counters stay inline.
- A single FSM always_ff with next-state always_comb.

Test Plan:
- Nominal bring-up (STABLE_CYCLES=8, align_timeout_value=100): link_enable=1, phy_ready=1 at cycle 0, rx_align_done at cycle 20 -> tx_online rises at cycle 10, rx_online/link_up rise at cycle 21, retry_count=0.
- PHY glitch in PHY_STABLE: phy_ready low 1 cycle after 5 stable cycles -> return to PHY_WAIT; tx_online rises only after 8 fresh consecutive ready cycles.
- Alignment timeout (align_timeout_value=10, max_retry=2, rx_align_done never): -> RETRAIN twice, retry_count=2, state FAILED=7 with outputs 0; link_enable 0 then 1 -> IDLE, retry_count=0, bring-up restarts.
- rx_align_err pulse in LINK_UP -> rx_online/tx_online low next cycle for 16 cycles, retry_count=1, then relock without software action.
- Simultaneous rx_align_done and timeout-expiry cycle -> LINK_UP, no retry increment; align_timeout_value=0 with 2^20 cycles of no alignment -> stays in ALIGN_WAIT, timer saturates at 0xFFFF in debug_status.
- rst_wr asserted for 1 cycle while in LINK_UP -> next cycle all outputs 0, link_state=0, debug_status=0.
